// File: rtl/raster_delta_gen.sv
// raster_delta_gen: walks a COLS x ROWS raster, one (dx, dy) pair per
// accepted valid/ready beat; start launches a pass, done pulses at end.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             launch a pass (IDLE only)
//   abort             cancel the current pass (RUN only)
//   out_ready         consumer accepts the current beat
//   out_valid         beat on out_dx/out_dy/out_last is valid
//   out_dx, out_dy    current column / row index
//   out_last          beat is (COLS-1, ROWS-1)
//   busy              pass in progress
//   done              one-cycle pulse after the pass ends
//   beat_count        beats accepted in the current/last pass
module raster_delta_gen #(
  parameter int DX_BITS = 8,
  parameter int DY_BITS = 8,
  parameter int COLS    = 4,
  parameter int ROWS    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DX_BITS-1:0] out_dx,
  output logic [DY_BITS-1:0] out_dy,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [15:0]        beat_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DX_BITS-1:0] X_MAX = DX_BITS'(COLS - 1);
  localparam logic [DY_BITS-1:0] Y_MAX = DY_BITS'(ROWS - 1);

  logic [1:0]         state_q, state_d;
  logic [DX_BITS-1:0] x_q, x_d;
  logic [DY_BITS-1:0] y_q, y_d;
  logic [15:0]        cnt_q, cnt_d;

  logic run;
  logic x_end;
  logic last;
  logic accept;

  assign run    = (state_q == S_RUN);
  assign x_end  = (x_q == X_MAX);
  assign last   = x_end && (y_q == Y_MAX);
  assign accept = run && out_ready;

  // Every output is decoded from state/index registers only.
  assign out_valid  = run;
  assign busy       = run;
  assign done       = (state_q == S_DONE);
  assign out_dx     = x_q;
  assign out_dy     = y_q;
  assign out_last   = run && last;
  assign beat_count = cnt_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
        // Abort wins over a same-cycle accept: the beat is counted
        // but the raster position is frozen.
        if (abort) begin
          state_d = S_DONE;
        end else if (accept) begin
          if (last) begin
            state_d = S_DONE;
          end else if (!x_end) begin
            x_d = x_q + DX_BITS'(1);
          end else begin
            x_d = '0;
            y_d = y_q + DY_BITS'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
